// File: rtl/sb_cfg_pkg.sv
// rtl/sb_cfg_pkg.sv - shared sizing helpers and field offsets for the configurable switch block
package sb_cfg_pkg;

  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_MUX_IN  = 4;
  localparam int SEL_LSB     = 0;

  // Ceiling log2; a single-entry space needs no select bits.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int field_w(input int mux_in);
    return clog2(mux_in) + 1;
  endfunction

  function automatic int chain_len(input int num_out, input int mux_in);
    return num_out * field_w(mux_in);
  endfunction

  // Enable bit sits directly above the select in each field.
  function automatic int en_bit(input int sel_w);
    return sel_w;
  endfunction

endpackage

// File: rtl/sb_cfg_param_if.sv
// rtl/sb_cfg_param_if.sv - configuration chain and status signals of the switch block
interface sb_cfg_param_if;
  logic ccff_head;
  logic cfg_shift_en;
  logic cfg_commit;
  logic ccff_tail;
  logic cfg_valid;
  logic cfg_err;

  modport master (
    output ccff_head,
    output cfg_shift_en,
    output cfg_commit,
    input  ccff_tail,
    input  cfg_valid,
    input  cfg_err
  );

  modport slave (
    input  ccff_head,
    input  cfg_shift_en,
    input  cfg_commit,
    output ccff_tail,
    output cfg_valid,
    output cfg_err
  );
endinterface

// File: rtl/sb_cfg_mux.sv
// rtl/sb_cfg_mux.sv - one gated routing mux; selects past the last input drive 0
module sb_cfg_mux #(
  parameter int MUX_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [MUX_IN-1:0] data,
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  localparam int PAD_N = 1 << SEL_W;

  generate
    if (PAD_N == MUX_IN) begin : g_pow2
      assign out = en & data[sel];
    end else begin : g_pad
      // Zero-fill the unused select codes so out-of-range selects read 0.
      logic [PAD_N-1:0] padded;
      assign padded = {{(PAD_N - MUX_IN){1'b0}}, data};
      assign out    = en & padded[sel];
    end
  endgenerate

endmodule

// File: rtl/sb_cfg_param.sv
// rtl/sb_cfg_param.sv - switch block with double-buffered, length-checked configuration chain
module sb_cfg_param
  import sb_cfg_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int MUX_IN  = DEF_MUX_IN
) (
  input  logic                      prog_clk,
  input  logic                      prog_reset,
  sb_cfg_param_if.slave             cfg,
  input  logic [NUM_OUT*MUX_IN-1:0] mux_in,
  output logic [NUM_OUT-1:0]        mux_out
);

  localparam int SEL_W     = clog2(MUX_IN);
  localparam int FIELD_W   = field_w(MUX_IN);
  localparam int CHAIN_LEN = chain_len(NUM_OUT, MUX_IN);
  localparam int CNT_W     = clog2(CHAIN_LEN + 2);
  localparam int EN_BIT    = en_bit(SEL_W);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] active;
  logic [CNT_W-1:0]     cnt;
  logic                 valid_q;
  logic                 err_q;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain   <= '0;
      active  <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (cfg.cfg_shift_en) begin
        chain <= {chain[CHAIN_LEN-2:0], cfg.ccff_head};
        // Saturating at CHAIN_LEN+1 keeps an overrun visible until the next reset or accept.
        if (cnt != CNT_SAT) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (cfg.cfg_commit) begin
        if (!cfg.cfg_shift_en && (cnt == CNT_FULL)) begin
          active  <= chain;
          cnt     <= '0;
          valid_q <= 1'b1;
          err_q   <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cfg.ccff_tail = chain[CHAIN_LEN-1];
  assign cfg.cfg_valid = valid_q;
  assign cfg.cfg_err   = err_q;

  generate
    for (genvar m = 0; m < NUM_OUT; m++) begin : g_mux
      sb_cfg_mux #(
        .MUX_IN (MUX_IN),
        .SEL_W  (SEL_W)
      ) u_mux (
        .data (mux_in[m*MUX_IN +: MUX_IN]),
        .en   (active[m*FIELD_W + EN_BIT]),
        .sel  (active[m*FIELD_W + SEL_LSB +: SEL_W]),
        .out  (mux_out[m])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sb_cfg_param.sv
// tb/tb_sb_cfg_param.sv - scoreboard bench for sb_cfg_param with 4-input and 3-input mux builds
module tb_sb_cfg_param;

  typedef struct {
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic       tail;
    logic       valid;
    logic       err;
  } exp_t;

  logic        prog_clk;
  logic        prog_reset;
  logic [15:0] mux_in_a;
  logic [11:0] mux_in_b;
  logic [3:0]  mux_out_a;
  logic [3:0]  mux_out_b;

  sb_cfg_param_if if_a ();
  sb_cfg_param_if if_b ();

  sb_cfg_param #(.NUM_OUT(4), .MUX_IN(4)) dut_a (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .cfg        (if_a),
    .mux_in     (mux_in_a),
    .mux_out    (mux_out_a)
  );

  sb_cfg_param #(.NUM_OUT(4), .MUX_IN(3)) dut_b (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .cfg        (if_b),
    .mux_in     (mux_in_b),
    .mux_out    (mux_out_b)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: the last 12 bits shifted in (oldest first), the loaded count, flags.
  logic        hist[$];
  logic [11:0] m_active;
  int          m_cnt;
  logic        m_valid;
  logic        m_err;

  function automatic logic [11:0] chain_word();
    logic [11:0] w;
    for (int k = 0; k < 12; k++) w[k] = hist[11 - k];
    return w;
  endfunction

  function automatic logic [3:0] route(input logic [11:0] act, input logic [15:0] mi, input int nin);
    logic [3:0] o;
    int sel;
    for (int m = 0; m < 4; m++) begin
      sel  = int'(act[m*3 +: 2]);
      o[m] = (act[m*3 + 2] && sel < nin) ? mi[m*nin + sel] : 1'b0;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic head, input logic sh,
                      input logic cm, input logic [15:0] mi);
    exp_t e;
    bit   ok;
    @(negedge prog_clk);
    prog_reset        = rst;
    if_a.ccff_head    = head;
    if_a.cfg_shift_en = sh;
    if_a.cfg_commit   = cm;
    if_b.ccff_head    = head;
    if_b.cfg_shift_en = sh;
    if_b.cfg_commit   = cm;
    mux_in_a          = mi;
    mux_in_b          = mi[11:0];
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 12; k++) hist.push_back(1'b0);
      m_active = '0;
      m_cnt    = 0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
    end else begin
      ok = cm && !sh && (m_cnt == 12);
      if (ok) begin
        m_active = chain_word();
        m_cnt    = 0;
        m_valid  = 1'b1;
        m_err    = 1'b0;
      end else if (cm) begin
        m_err = 1'b1;
      end
      if (sh) begin
        hist.push_back(head);
        void'(hist.pop_front());
        m_cnt = (m_cnt + 1 > 13) ? 13 : m_cnt + 1;
      end
    end
    e.out_a = route(m_active, mi, 4);
    e.out_b = route(m_active, {4'b0, mi[11:0]}, 3);
    e.tail  = hist[0];
    e.valid = m_valid;
    e.err   = m_err;
    sbq.push_back(e);
  endtask

  task automatic load_word(input logic [11:0] w, input int n, input logic [15:0] mi);
    for (int i = 0; i < n; i++) step(1'b0, w[11 - (i % 12)], 1'b1, 1'b0, mi);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge prog_clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("mux_out_a", mux_out_a, e.out_a);
        check("mux_out_b", mux_out_b, e.out_b);
        check("ccff_tail_a", {3'b0, if_a.ccff_tail}, {3'b0, e.tail});
        check("ccff_tail_b", {3'b0, if_b.ccff_tail}, {3'b0, e.tail});
        check("cfg_valid_a", {3'b0, if_a.cfg_valid}, {3'b0, e.valid});
        check("cfg_valid_b", {3'b0, if_b.cfg_valid}, {3'b0, e.valid});
        check("cfg_err_a", {3'b0, if_a.cfg_err}, {3'b0, e.err});
        check("cfg_err_b", {3'b0, if_b.cfg_err}, {3'b0, e.err});
      end
    end
  end

  initial begin : stimulus
    logic [15:0] mi;
    logic [11:0] w;
    int          r;
    prog_reset        = 1'b1;
    if_a.ccff_head    = 1'b0;
    if_a.cfg_shift_en = 1'b0;
    if_a.cfg_commit   = 1'b0;
    if_b.ccff_head    = 1'b0;
    if_b.cfg_shift_en = 1'b0;
    if_b.cfg_commit   = 1'b0;
    mux_in_a          = 16'hFFFF;
    mux_in_b          = 12'hFFF;

    // Reset with every mux input high.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // Good load, one-hot inputs, then inputs cleared.
    load_word(12'b111_110_101_100, 12, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'b1000_0100_0010_0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // Short load rejected, then completed.
    load_word(12'b101_100_111_110, 11, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hA5C3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h5A3C);

    // Overrun: 14 shifts, tail replays the first two bits.
    load_word(12'b011_001_110_100, 14, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);

    // Reset, full load, then shift+commit together at cnt==12.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    load_word(12'b100_101_110_111, 12, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // Reset mid-load, then a clean load.
    load_word(12'b111_111_111_111, 6, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    load_word(12'b111_111_110_101, 12, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h8421);

    // Random full loads with random routing inputs.
    for (int n = 0; n < 20; n++) begin
      w = 12'($urandom());
      load_word(w, 12, 16'($urandom()));
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'($urandom()));
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom()));
    end

    // Unconstrained random control traffic.
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      mi = 16'($urandom());
      step(r < 2, 1'($urandom()), (r >= 2 && r < 70) || r >= 95, r >= 85, mi);
    end

    repeat (4) @(posedge prog_clk);
    #2;
    check("scoreboard_drained", sbq.size() == 0 ? 4'd0 : 4'd1, 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_cfg_param.md
# sb_cfg_param

Parametrised switch block with a self-checking configuration chain. It drives `NUM_OUT` routed output tracks, each through a `MUX_IN`-input mux with a per-mux enable. Configuration is double-buffered: bits shift through a chain, and a commit strobe copies them atomically into the active registers. The block sits in the routing fabric between grid tiles and daisy-chains on `ccff_head`/`ccff_tail` like the other switch blocks. Fixed shorts (track-to-track wires) stay in the parent wrapper, which also assembles `mux_in` from channel and pin nets.

## Interface
- `NUM_OUT`, default 4: number of routed output muxes.
- `MUX_IN`, default 4: inputs per mux, at least 2, not required to be a power of two.
- `SEL_W`, derived: `clog2(MUX_IN)`; default 2.
- `FIELD_W`, derived: `SEL_W+1`; one enable bit plus the select.
- `CHAIN_LEN`, derived: `NUM_OUT*FIELD_W`; default 12.

Ports:
- `prog_clk`, in, 1: the single clock; all state is on the rising edge.
- `prog_reset`, in, 1: synchronous, active-high reset.
- `ccff_head`, in, 1: configuration chain serial input.
- `cfg_shift_en`, in, 1: shift the chain one bit this cycle.
- `cfg_commit`, in, 1: copy the chain into the active config.
- `mux_in`, in, `NUM_OUT*MUX_IN`: mux m input i is bit `m*MUX_IN+i`.
- `mux_out`, out, `NUM_OUT`: routed track outputs.
- `ccff_tail`, out, 1: chain bit `CHAIN_LEN-1`, registered.
- `cfg_valid`, out, 1: at least one successful commit since reset.
- `cfg_err`, out, 1: sticky commit-error flag.

## Operation
- **Chain.** `chain[CHAIN_LEN-1:0]`. On `cfg_shift_en`: `chain <= {chain[CHAIN_LEN-2:0], ccff_head}`. With no shift, the chain holds.
  - The first bit shifted in ends at `CHAIN_LEN-1`, so the loader sends the MSB first.
- **Field layout.** Mux m uses `chain[m*FIELD_W +: FIELD_W]` = {en, sel}, with en at the MSB.
- **Bit counter.** `cnt` is `clog2(CHAIN_LEN+2)` bits wide.
  - Increments on each shift and saturates at `CHAIN_LEN+1`, which marks an overrun. It never wraps.
- **Commit accepted** when `cfg_commit` is high, `cfg_shift_en` is low, and `cnt==CHAIN_LEN`. Then:
  - `active <= chain`
  - `cnt <= 0`
  - `cfg_valid <= 1`
  - `cfg_err <= 0`
- **Commit rejected** when `cnt!=CHAIN_LEN`, or when `cfg_commit` and `cfg_shift_en` are high together.
  - `active` is unchanged, `cfg_err <= 1`, and `cnt` is unchanged.
  - In the simultaneous case the shift still happens and `cnt` still increments.
- **Mux output (combinational)** from `active` and `mux_in`:
  - en=0: output is 0.
  - en=1 and sel<MUX_IN: output is `mux_in[m*MUX_IN+sel]`.
  - en=1 and sel>=MUX_IN (only possible when `MUX_IN` is not a power of two): output is 0.
- **Reset values:**
  - chain=0, active=0, cnt=0.
  - `mux_out`=0, `ccff_tail`=0, `cfg_valid`=0, `cfg_err`=0.
- **Reset mid-load:** all progress is discarded, and the next load restarts from cnt=0.
- **Shift after a good commit:** the active config does not change until the next accepted commit.

## Timing
- Shift: `ccff_tail` shows the new chain MSB one cycle after the `cfg_shift_en` edge. Latency from `ccff_head` to `ccff_tail` is `CHAIN_LEN` shift cycles.
- Commit: `active`, `cfg_valid` and `cfg_err` update at the commit edge. `mux_out` reflects the new config in the same cycle after that edge.
- `mux_in` to `mux_out` is purely combinational, with no latency.
- Reset has priority over shift and commit in the same cycle.

## Structure
- Package `sb_cfg_pkg` holds:
  - the `clog2` function;
  - `FIELD_W`/`CHAIN_LEN` derivation functions;
  - field offset constants `EN_BIT=SEL_W` and `SEL_LSB=0`.
- Sub-module `sb_cfg_mux`, one per output, generated `NUM_OUT` times:
  - inputs: `MUX_IN` data bits, en, sel;
  - gated output, with the out-of-range sel check.
- Top level holds the chain, counter, active registers and flags.

## Test plan
Defaults apply: `NUM_OUT=4`, `MUX_IN=4`, `CHAIN_LEN=12`.
- **Reset:** after reset, with `mux_in` all ones -> `mux_out=0`, `cfg_valid=0`, `cfg_err=0`, `ccff_tail=0`.
- **Good load:** shift 12'b111_110_101_100 MSB first, then commit; drive `mux_in=16'b1000_0100_0010_0001` -> `mux_out=4'b1111`. Change `mux_in=0` -> `mux_out=0`.
- **Short load:** 11 shifts then commit -> `cfg_err=1`, previous `mux_out` unchanged. Then 1 more shift and commit -> `cfg_err=0`, new config active.
- **Overrun:** 14 shifts then commit -> `cfg_err=1`. `ccff_tail` across shifts 13 and 14 equals the bits shifted in at shifts 1 and 2.
- **Simultaneous shift and commit** at cnt=12 -> commit rejected, `cfg_err=1`, cnt saturated at 13.
- **Out-of-range select:** `MUX_IN=3`, field {1,2'b11} -> output 0. Reset mid-load (after 6 shifts) then 12 shifts and commit -> clean load, `cfg_err=0`.
